// File: rtl/key_debounce_pulse.sv
// Push-button conditioner: synchronises the active-low KEY_3, debounces it and
// emits one-cycle count-enable pulses per accepted press, with optional auto-repeat.
module key_debounce_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          REPEAT_EN       = 1'b0,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 5000000,
  parameter int unsigned CNT_W           = 25
) (
  input  logic CLOCK_50,
  input  logic SW17,
  input  logic KEY_3,
  output logic KEY_PULSE,
  output logic KEY_LEVEL
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 32'd1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             key_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             phase_q, phase_d;   // 0 = waiting for first repeat, 1 = repeating
  logic             pulse_q, pulse_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] rep_limit;

  // Two-stage synchroniser; resets to the released level
  always_comb begin
    sync1_d = KEY_3;
    sync2_d = sync1_q;
  end

  assign key_s     = ~sync2_q;
  assign rep_limit = phase_q ? REP_LAST : HOLD_LAST;

  always_ff @(posedge CLOCK_50 or posedge SW17) begin
    if (SW17) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      timer_q <= '0;
      phase_q <= 1'b0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      timer_q <= timer_d;
      phase_q <= phase_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    phase_d = phase_q;
    pulse_d = 1'b0;
    level_d = level_q;

    unique case (state_q)
      IDLE: begin
        level_d = 1'b0;
        if (key_s) begin
          state_d = DB_PRESS;
          timer_d = '0;
        end
      end

      DB_PRESS: begin
        if (!key_s) begin
          state_d = IDLE;
        end else if (timer_q == DB_LAST) begin
          state_d = HELD;
          pulse_d = 1'b1;
          level_d = 1'b1;
          timer_d = '0;
          phase_d = 1'b0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end

      HELD: begin
        level_d = 1'b1;
        if (!key_s) begin
          state_d = DB_RELEASE;
          timer_d = '0;
        end else if (REPEAT_EN) begin
          if (timer_q == rep_limit) begin
            pulse_d = 1'b1;
            timer_d = '0;
            phase_d = 1'b1;
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
      end

      DB_RELEASE: begin
        // A press seen mid-release restarts hold timing without a new pulse
        if (key_s) begin
          state_d = HELD;
          timer_d = '0;
          phase_d = 1'b0;
        end else if (timer_q == DB_LAST) begin
          state_d = IDLE;
          level_d = 1'b0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        timer_d = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign KEY_PULSE = pulse_q;
  assign KEY_LEVEL = level_q;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Scoreboard bench for key_debounce_pulse: one instance without and one with auto-repeat,
// expected pulse cycles queued at stimulus time and matched when pulses appear.
module tb_key_debounce_pulse;

  localparam int DB   = 4;
  localparam int HOLD = 8;
  localparam int REP  = 3;
  localparam int LAT  = DB + 3;   // drive-to-visible-pulse delay in cycles

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic key_n = 1'b1;
  logic pulse0, level0, pulse1, level1;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;
  int cnt0     = 0;
  int cnt1     = 0;
  int q0[$];
  int q1[$];

  key_debounce_pulse #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1'b0), .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP), .CNT_W(4)
  ) dut (
    .CLOCK_50(clk), .SW17(rst), .KEY_3(key_n), .KEY_PULSE(pulse0), .KEY_LEVEL(level0)
  );

  key_debounce_pulse #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1'b1), .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP), .CNT_W(4)
  ) dut_rep (
    .CLOCK_50(clk), .SW17(rst), .KEY_3(key_n), .KEY_PULSE(pulse1), .KEY_LEVEL(level1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Matches every observed pulse against the head of its scoreboard queue
  task automatic monitor();
    logic prev0 = 1'b0;
    logic prev1 = 1'b0;
    forever begin
      @(negedge clk);
      if (pulse0) begin
        check_eq("pulse0_one_cycle", 32'(prev0), 32'd0);
        check_eq("pulse0_expected", 32'(q0.size() != 0), 32'd1);
        if (q0.size() != 0) check_eq("pulse0_cycle", cyc, q0.pop_front());
        cnt0++;
      end
      if (pulse1) begin
        check_eq("pulse1_one_cycle", 32'(prev1), 32'd0);
        check_eq("pulse1_expected", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) check_eq("pulse1_cycle", cyc, q1.pop_front());
        cnt1++;
      end
      prev0 = pulse0;
      prev1 = pulse1;
    end
  endtask

  task automatic check_levels(input string tag, input logic exp);
    check_eq({tag, "_lvl0"}, 32'(level0), 32'(exp));
    check_eq({tag, "_lvl1"}, 32'(level1), 32'(exp));
  endtask

  task automatic check_drained();
    check_eq("q0_drained", q0.size(), 0);
    check_eq("q1_drained", q1.size(), 0);
  endtask

  // Clean press held for 'hold' cycles (>= LAT+1), then clean release
  task automatic press_release(input int hold);
    int c;
    int t;
    key_n = 1'b0;
    c = cyc;
    q0.push_back(c + LAT);
    q1.push_back(c + LAT);
    t = c + LAT + HOLD;
    while (t <= c + hold + 2) begin
      q1.push_back(t);
      t += REP;
    end
    step(LAT - 1);
    check_levels("press_pre", 1'b0);
    step(1);
    check_levels("press_post", 1'b1);
    step(hold - LAT);
    key_n = 1'b1;
    step(LAT - 1);
    check_levels("release_pre", 1'b1);
    step(1);
    check_levels("release_post", 1'b0);
    step(3);
    check_drained();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b0;
    int b1;
    int f;
    fork
      monitor();
    join_none

    // 1: reset values, async reset during a pulse, press held across reset release
    step(3);
    check_eq("rst_pulse0", 32'(pulse0), 32'd0);
    check_eq("rst_pulse1", 32'(pulse1), 32'd0);
    check_levels("rst", 1'b0);
    rst = 1'b0;
    step(2);
    key_n = 1'b0;
    step(LAT);
    check_eq("pre_rst_pulse0", 32'(pulse0), 32'd1);
    check_levels("pre_rst", 1'b1);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_pulse0", 32'(pulse0), 32'd0);
    check_eq("async_rst_pulse1", 32'(pulse1), 32'd0);
    check_levels("async_rst", 1'b0);
    step(2);
    b0 = cnt0;
    rst = 1'b0;
    press_release(12);
    check_eq("post_rst_pulses", cnt0 - b0, 1);

    // 2: clean press, long hold
    press_release(20);

    // 3: press bounce then stable low
    key_n = 1'b0; step(3);
    key_n = 1'b1; step(1);
    key_n = 1'b0; step(2);
    key_n = 1'b1; step(1);
    b0 = cnt0;
    press_release(10);
    check_eq("bounce_pulses", cnt0 - b0, 1);

    // 4: release bounce while held
    key_n = 1'b0;
    q0.push_back(cyc + LAT);
    q1.push_back(cyc + LAT);
    step(LAT + 1);
    key_n = 1'b1; step(3);
    key_n = 1'b0; step(1);
    key_n = 1'b1;
    f = cyc;
    step(1);
    check_levels("rel_glitch", 1'b1);
    step(LAT - 2);
    check_levels("rel_bounce_pre", 1'b1);
    step(1);
    check_levels("rel_bounce_post", 1'b0);
    check_eq("rel_bounce_cycle", cyc - f, LAT);
    step(3);
    check_drained();

    // 5: auto-repeat over a long hold
    b0 = cnt0;
    b1 = cnt1;
    press_release(30);
    check_eq("repeat_count", cnt1 - b1, 7);
    check_eq("no_repeat_count", cnt0 - b0, 1);

    // 6: reset mid-debounce, then ten clean presses
    key_n = 1'b0;
    b0 = cnt0;
    step(5);
    rst = 1'b1;
    #1;
    check_eq("mid_db_rst_pulse0", 32'(pulse0), 32'd0);
    check_levels("mid_db_rst", 1'b0);
    step(3);
    rst = 1'b0;
    press_release(10);
    check_eq("mid_db_rst_pulses", cnt0 - b0, 1);

    b0 = cnt0;
    repeat (10) press_release(8);
    check_eq("ten_presses", cnt0 - b0, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
